pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, output word FIFO entries; power of two, 2..16.
REQ-002 Parameter PAD_BYTE, default 8'h00, fill value for unfilled lanes of a partial word.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream byte valid.
REQ-006 in_ready  output  1  packer accepts a byte this cycle.
REQ-007 in_pixel  input  8  unsigned 8-bit pixel.
REQ-008 in_last  input  1  marks final pixel of a line/packet.
REQ-009 out_valid  output  1  head FIFO word valid toward the SIMD operand port.
REQ-010 out_ready  input  1  downstream SIMD stage takes the word.
REQ-011 out_word  output  32  four packed pixels, pixel 0 in [7:0], pixel 3 in [31:24].
REQ-012 out_keep  output  4  per-lane valid mask, bit i covers byte lane i.
REQ-013 out_last  output  1  word closes a packet.
REQ-014 fifo_count  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-015 A byte SHALL be accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-016 in_ready SHALL equal (fifo_count < FIFO_DEPTH) and SHALL NOT depend combinationally on out_ready, in_valid or in_last.
REQ-017 A 2-bit lane counter SHALL place each accepted byte into lane lane_cnt of the pack register, then increment modulo 4.
REQ-018 A word SHALL complete when the byte accepted is in lane 3 or carries in_last=1; on completion the word SHALL be written to the FIFO at that edge and lane_cnt SHALL return to 0.
REQ-019 Full word: out_keep=4'b1111, out_last=in_last of the lane-3 byte.
REQ-020 Partial word (in_last in lane k<3): lanes 0..k = accepted bytes, lanes k+1..3 = PAD_BYTE, out_keep = 0001/0011/0111 for k=0/1/2, out_last=1.
REQ-021 Latency: word completed at edge N SHALL present out_valid=1 from cycle N+1 when the FIFO was empty.
REQ-022 out_valid SHALL equal (fifo_count != 0); out_word/out_keep/out_last SHALL reflect the FIFO head.
REQ-023 A pop SHALL occur on out_valid=1 and out_ready=1; head outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Simultaneous push and pop SHALL leave fifo_count unchanged; push-only +1; pop-only -1.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; words SHALL emerge in acceptance order.
REQ-026 When full, in_ready=0 and pack register and lane_cnt SHALL hold; partially packed bytes are kept.
REQ-027 in_last with in_valid=0 or in_ready=0 SHALL have no effect.

Reset
REQ-028 While rst=1: fifo_count=0, pointers=0, lane_cnt=0, pack register=0, out_valid=0, out_word=0, out_keep=0, out_last=0, in_ready=0.
REQ-029 Reset asserted mid-packet or with words buffered SHALL discard all partial bytes and FIFO contents; no stale data after release.
REQ-030 First cycle after rst deasserts: in_ready=1, out_valid=0.

Verification
REQ-031 Bytes C8,64,FF,00 back-to-back, out_ready=1 -> one cycle after 4th byte: out_word=0x00FF64C8, keep=1111, last=0, single-cycle out_valid.
REQ-032 Bytes 01..06, in_last on 06 -> 0x04030201 keep=1111 last=0, then 0x00000605 keep=0011 last=1.
REQ-033 Single byte AB with in_last, PAD_BYTE=00 -> out_word=0x000000AB, keep=0001, last=1.
REQ-034 out_ready=0, stream 20 bytes -> fifo_count reaches 4, in_ready=0, head stays 0x04030201; out_ready=1 -> 4 words in order, then remaining bytes packed, no loss or duplication.
REQ-035 fifo_count=2, push and pop in same cycle -> fifo_count stays 2, order preserved.
REQ-036 Accept 2 bytes, pulse rst asynchronously mid-cycle -> outputs zero immediately; then bytes 11,22,33,44 -> out_word=0x44332211, keep=1111.

Source files
------------

// File: rtl/pixel_packer.sv
// Packs an 8-bit pixel stream into 32-bit words with lane keep masks.
// Completed words queue in a small FIFO toward the SIMD operand port.
module pixel_packer #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] PAD_BYTE   = 8'h00
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_pixel,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [31:0]                   out_word,
    output logic [3:0]                    out_keep,
    output logic                          out_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [1:0]    lane_cnt;
    logic [31:0]   pack;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [31:0] mem_word [FIFO_DEPTH];
    logic [3:0]  mem_keep [FIFO_DEPTH];
    logic        mem_last [FIFO_DEPTH];

    logic        accept;
    logic        done;
    logic        push;
    logic        pop;
    logic [31:0] new_word;
    logic [3:0]  new_keep;

    assign in_ready = !rst && (count < CW'(FIFO_DEPTH));
    assign accept   = in_valid && in_ready;
    assign done     = accept && ((lane_cnt == 2'd3) || in_last);
    assign push     = done;
    assign pop      = out_valid && out_ready;

    // Lanes below the current one come from the pack register,
    // the current lane takes the incoming byte, the rest are padded.
    always_comb begin
        new_word = '0;
        new_keep = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < int'(lane_cnt)) begin
                new_word[i*8 +: 8] = pack[i*8 +: 8];
                new_keep[i]        = 1'b1;
            end else if (i == int'(lane_cnt)) begin
                new_word[i*8 +: 8] = in_pixel;
                new_keep[i]        = 1'b1;
            end else begin
                new_word[i*8 +: 8] = PAD_BYTE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_cnt <= '0;
            pack     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (accept) begin
                if (done) begin
                    lane_cnt <= '0;
                    pack     <= '0;
                end else begin
                    pack[{lane_cnt, 3'b000} +: 8] <= in_pixel;
                    lane_cnt <= lane_cnt + 2'd1;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr] <= new_word;
            mem_keep[wr_ptr] <= new_keep;
            mem_last[wr_ptr] <= in_last;
        end
    end

    // Head is masked when empty so nothing stale leaks after reset.
    assign out_valid  = (count != '0);
    assign out_word   = out_valid ? mem_word[rd_ptr] : '0;
    assign out_keep   = out_valid ? mem_keep[rd_ptr] : '0;
    assign out_last   = out_valid ? mem_last[rd_ptr] : 1'b0;
    assign fifo_count = count;

endmodule

// File: tb/tb_pixel_packer.sv
// Testbench for pixel_packer: directed scenarios plus a randomized
// stream scored against a queue-based reference of completed words.
module tb_pixel_packer;

    localparam int         D   = 4;
    localparam logic [7:0] PAD = 8'h00;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_pixel;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [3:0]  out_keep;
    logic        out_last;
    logic [$clog2(D):0] fifo_count;

    pixel_packer #(.FIFO_DEPTH(D), .PAD_BYTE(PAD)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pixel   (in_pixel),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_word   (out_word),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [3:0]  k;
        logic        l;
    } wd_t;

    wd_t        q[$];
    logic [7:0] pend[$];

    int n_run  = 0;
    int n_fail = 0;

    task automatic model_clr();
        q.delete();
        pend.delete();
    endtask

    // Called right after a falling edge; settles inputs before checks.
    task automatic drive(input logic v, input logic [7:0] pix,
                         input logic lst, input logic ordy);
        in_valid  = v;
        in_pixel  = pix;
        in_last   = lst;
        out_ready = ordy;
        #1;
    endtask

    // Advance the reference by one clock, then move to the next falling edge.
    task automatic tick();
        bit  acc;
        bit  pp;
        wd_t e;
        acc = in_valid && (q.size() < D);
        pp  = (q.size() != 0) && out_ready;
        if (pp) void'(q.pop_front());
        if (acc) begin
            pend.push_back(in_pixel);
            if (pend.size() == 4 || in_last) begin
                e.w = '0;
                for (int i = 0; i < 4; i++)
                    e.w[i*8 +: 8] = (i < pend.size()) ? pend[i] : PAD;
                e.k = 4'((1 << pend.size()) - 1);
                e.l = in_last;
                q.push_back(e);
                pend.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; in_pixel = 0; in_last = 0; out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        n_run++;
        if ({out_valid, out_word, out_keep, out_last} !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_out: got v=%b w=%h k=%b l=%b want zeros",
                     out_valid, out_word, out_keep, out_last);
        end
        n_run++;
        if (fifo_count !== 0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_cnt: got cnt=%0d rdy=%b want 0/0",
                     fifo_count, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clr();
        #1;
        n_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got rdy=%b v=%b want 1/0",
                     in_ready, out_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_full_word();
        logic [7:0] b[4] = '{8'hC8, 8'h64, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(1, b[i], 0, 1);
            tick();
        end
        drive(0, 0, 0, 1);
        n_run++;
        if (out_valid !== 1'b1 || out_word !== 32'h00FF64C8 ||
            out_keep !== 4'hF || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word: got v=%b w=%h k=%b l=%b want 1 00ff64c8 1111 0",
                     out_valid, out_word, out_keep, out_last);
        end
        tick();
        drive(0, 0, 0, 1);
        n_run++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL full_word_pulse: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_partial();
        for (int i = 1; i <= 6; i++) begin
            drive(1, 8'(i), i == 6, 1);
            if (i == 5) begin
                n_run++;
                if (out_valid !== 1'b1 || out_word !== 32'h04030201 ||
                    out_keep !== 4'hF || out_last !== 1'b0) begin
                    n_fail++;
                    $display("FAIL partial_w0: got v=%b w=%h k=%b l=%b want 1 04030201 1111 0",
                             out_valid, out_word, out_keep, out_last);
                end
            end
            tick();
        end
        drive(0, 0, 0, 1);
        n_run++;
        if (out_valid !== 1'b1 || out_word !== 32'h00000605 ||
            out_keep !== 4'b0011 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL partial_w1: got v=%b w=%h k=%b l=%b want 1 00000605 0011 1",
                     out_valid, out_word, out_keep, out_last);
        end
        tick();
    endtask

    task automatic test_single();
        drive(1, 8'hAB, 1, 1);
        tick();
        drive(0, 0, 0, 1);
        n_run++;
        if (out_valid !== 1'b1 || out_word !== 32'h000000AB ||
            out_keep !== 4'b0001 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single: got v=%b w=%h k=%b l=%b want 1 000000ab 0001 1",
                     out_valid, out_word, out_keep, out_last);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp[5] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09,
                                32'h100F0E0D, 32'h14131211};
        logic [31:0] got[$];
        int nb = 1;
        int cyc = 0;
        while (nb <= 16 && cyc < 40) begin
            drive(1, 8'(nb), 0, 0);
            if (q.size() < D) nb++;
            tick();
            cyc++;
        end
        repeat (3) begin
            drive(1, 8'(nb), 0, 0);
            tick();
        end
        drive(1, 8'(nb), 0, 0);
        n_run++;
        if (fifo_count !== D || in_ready !== 1'b0 || out_word !== 32'h04030201) begin
            n_fail++;
            $display("FAIL bp_full: got cnt=%0d rdy=%b w=%h want 4 0 04030201",
                     fifo_count, in_ready, out_word);
        end
        cyc = 0;
        while ((nb <= 20 || out_valid) && cyc < 60) begin
            drive(nb <= 20, 8'(nb), 0, 1);
            if (out_valid) got.push_back(out_word);
            if (nb <= 20 && q.size() < D) nb++;
            tick();
            cyc++;
        end
        n_run++;
        if (got.size() != 5) begin
            n_fail++;
            $display("FAIL bp_count: got %0d words want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            n_run++;
            if (got[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_push_pop();
        for (int i = 0; i < 11; i++) begin
            drive(1, 8'(8'h21 + i), 0, 0);
            tick();
        end
        drive(1, 8'h2C, 0, 1);
        n_run++;
        if (fifo_count !== 2) begin
            n_fail++;
            $display("FAIL pp_pre: got cnt=%0d want 2", fifo_count);
        end
        tick();
        drive(0, 0, 0, 0);
        n_run++;
        if (fifo_count !== 2 || out_word !== 32'h28272625) begin
            n_fail++;
            $display("FAIL pp_same: got cnt=%0d w=%h want 2 28272625",
                     fifo_count, out_word);
        end
        drive(0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 1);
        n_run++;
        if (fifo_count !== 1 || out_word !== 32'h2C2B2A29) begin
            n_fail++;
            $display("FAIL pp_order: got cnt=%0d w=%h want 1 2c2b2a29",
                     fifo_count, out_word);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            drive(1, 8'(8'h50 + i), 0, 0);
            tick();
        end
        drive(0, 0, 0, 0);
        rst = 1'b1;
        #1;
        n_run++;
        if (out_valid !== 1'b0 || out_word !== 32'd0 || fifo_count !== 0 ||
            in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b w=%h cnt=%0d rdy=%b want 0 0 0 0",
                     out_valid, out_word, fifo_count, in_ready);
        end
        #1;
        rst = 1'b0;
        model_clr();
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 8'(8'h11 * i), 0, 1);
            tick();
        end
        drive(0, 0, 0, 1);
        n_run++;
        if (out_valid !== 1'b1 || out_word !== 32'h44332211 || out_keep !== 4'hF) begin
            n_fail++;
            $display("FAIL rst_after: got v=%b w=%h k=%b want 1 44332211 1111",
                     out_valid, out_word, out_keep);
        end
        tick();
    endtask

    task automatic test_random();
        int bad = 0;
        for (int c = 0; c < 500; c++) begin
            drive($urandom_range(0, 9) < 7, 8'($urandom),
                  $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 5);
            if (out_valid !== (q.size() != 0) || fifo_count !== q.size() ||
                in_ready !== (q.size() < D)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL rnd_ctl c=%0d: got v=%b cnt=%0d rdy=%b want model size %0d",
                             c, out_valid, fifo_count, in_ready, q.size());
            end else if (q.size() != 0 && (out_word !== q[0].w ||
                         out_keep !== q[0].k || out_last !== q[0].l)) begin
                bad++;
                if (bad < 5)
                    $display("FAIL rnd_head c=%0d: got %h/%b/%b want %h/%b/%b",
                             c, out_word, out_keep, out_last,
                             q[0].w, q[0].k, q[0].l);
            end
            tick();
        end
        n_run++;
        if (bad != 0) n_fail++;
        for (int c = 0; c < 20 && q.size() != 0; c++) begin
            drive(0, 0, 0, 1);
            tick();
        end
        drive(0, 0, 0, 1);
        n_run++;
        if (fifo_count !== 0 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_drain: got cnt=%0d model %0d want 0",
                     fifo_count, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_single();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
